// File: rtl/sync_down_counter_pkg.sv
// Shared types for the loadable down-counter/timer.
package sync_down_counter_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  localparam int unsigned MinWidth = 2;

endpackage

// File: rtl/sync_down_counter_if.sv
// Control/status bundle of the down-counter; master drives controls, slave is the counter.
interface sync_down_counter_if #(
  parameter int unsigned WIDTH = 4
);

  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             busy;

  modport master (
    output en, load, load_val, auto_reload,
    input  Q, tc, busy
  );

  modport slave (
    input  en, load, load_val, auto_reload,
    output Q, tc, busy
  );

endinterface

// File: rtl/sync_down_counter.sv
// Loadable down-counter: counts a loaded value to zero, pulses tc, optionally auto-reloads.
module sync_down_counter
  import sync_down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  sync_down_counter_if.slave   bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    // Load beats a coincident terminal event, so tc stays low on that edge.
    if (bus.load) begin
      count_d  = bus.load_val;
      reload_d = bus.load_val;
      state_d  = (bus.load_val != '0) ? StRun : StIdle;
    end else if (state_q == StRun && bus.en) begin
      if (count_q == One) begin
        tc_d = 1'b1;
        if (bus.auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = StIdle;
        end
      end else begin
        count_d = count_q - One;
      end
    end
  end

  assign bus.Q    = count_q;
  assign bus.tc   = tc_q;
  assign bus.busy = (state_q == StRun);

endmodule

// File: tb/tb_sync_down_counter.sv
// Directed bench for sync_down_counter with a cycle-level reference model and literal pins.
module tb_sync_down_counter;

  localparam int unsigned WIDTH = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  sync_down_counter_if #(.WIDTH(WIDTH)) bus ();

  sync_down_counter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: remaining ticks, programmed period, and whether a countdown is live.
  int m_q     = 0;
  int m_rel   = 0;
  bit m_run   = 1'b0;
  bit m_tc    = 1'b0;
  bit cmp_en  = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q   = 0;
      m_rel = 0;
      m_run = 1'b0;
      m_tc  = 1'b0;
    end else begin
      m_tc = 1'b0;
      if (bus.load) begin
        m_q   = int'(bus.load_val);
        m_rel = m_q;
        m_run = (m_q > 0);
      end else if (m_run && bus.en) begin
        m_q = m_q - 1;
        if (m_q == 0) begin
          m_tc = 1'b1;
          if (bus.auto_reload) m_q = m_rel;
          else m_run = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_Q", int'(bus.Q), m_q);
      chk("model_tc", int'(bus.tc), int'(m_tc));
      chk("model_busy", int'(bus.busy), int'(m_run));
    end
  end

  task automatic drive(input bit l, input int v, input bit e, input bit ar);
    bus.load        = l;
    bus.load_val    = WIDTH'(v);
    bus.en          = e;
    bus.auto_reload = ar;
  endtask

  // Apply inputs, let one rising edge pass, return at the following falling edge.
  task automatic cyc(input bit l, input int v, input bit e, input bit ar);
    drive(l, v, e, ar);
    @(negedge clk);
  endtask

  int exp_one[4]  = '{3, 2, 1, 0};
  int exp_per[12] = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2, 1, 3};
  int tc_cnt;
  int edges;

  initial begin
    rst = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("reset_Q", int'(bus.Q), 0);
    chk("reset_busy", int'(bus.busy), 0);
    rst = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;

    // Asynchronous reset mid-count at Q=5
    cyc(1'b1, 7, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("pre_reset_Q", int'(bus.Q), 5);
    drive(1'b0, 0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("async_Q", int'(bus.Q), 0);
    chk("async_tc", int'(bus.tc), 0);
    chk("async_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 0, 1'b1, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("no_resume_Q", int'(bus.Q), 0);

    // One-shot from 4
    cyc(1'b1, 4, 1'b1, 1'b0);
    chk("oneshot_load_Q", int'(bus.Q), 4);
    chk("oneshot_load_busy", int'(bus.busy), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 0, 1'b1, 1'b0);
      chk("oneshot_Q", int'(bus.Q), exp_one[i]);
      chk("oneshot_tc", int'(bus.tc), (i == 3) ? 1 : 0);
      chk("oneshot_busy", int'(bus.busy), (i == 3) ? 0 : 1);
    end
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("oneshot_tc_clear", int'(bus.tc), 0);
    cyc(1'b0, 0, 1'b1, 1'b1);
    chk("idle_en_ignored_Q", int'(bus.Q), 0);

    // Periodic reload of 3
    cyc(1'b1, 3, 1'b0, 1'b1);
    tc_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 0, 1'b1, 1'b1);
      chk("periodic_Q", int'(bus.Q), exp_per[i]);
      chk("periodic_busy", int'(bus.busy), 1);
      tc_cnt += int'(bus.tc);
    end
    chk("periodic_tc_count", tc_cnt, 4);

    // Enable gating from 6: tc on the 6th enabled edge (11th edge overall)
    cyc(1'b1, 6, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      cyc(1'b0, 0, (i % 2 == 0), 1'b0);
      if (i < 10) chk("gate_no_tc", int'(bus.tc), 0);
    end
    chk("gate_Q", int'(bus.Q), 0);
    chk("gate_tc", int'(bus.tc), 1);

    // Corner: load of zero stays idle
    cyc(1'b1, 0, 1'b1, 1'b1);
    chk("zero_Q", int'(bus.Q), 0);
    chk("zero_busy", int'(bus.busy), 0);
    chk("zero_tc", int'(bus.tc), 0);

    // Corner: load coincides with terminal event
    cyc(1'b1, 2, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("coinc_pre_Q", int'(bus.Q), 1);
    cyc(1'b1, 9, 1'b1, 1'b0);
    chk("coinc_Q", int'(bus.Q), 9);
    chk("coinc_tc", int'(bus.tc), 0);
    chk("coinc_busy", int'(bus.busy), 1);

    // Corner: full-scale 15 takes 15 enabled edges
    cyc(1'b1, 15, 1'b0, 1'b0);
    edges = 0;
    while (bus.tc !== 1'b1 && edges < 40) begin
      cyc(1'b0, 0, 1'b1, 1'b0);
      edges++;
    end
    chk("full_scale_edges", edges, 15);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
